// File: rtl/sc_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sc_fifo_wr_arb
// Description : Round-robin write arbiter sharing one single-clock FIFO write
//               port among NREQ producers. A grant lasts for up to BURST
//               accepted words or until the owner flags its last word. Writes
//               stall on FIFO full; new grants wait while almost-full is set.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_fifo_wr_arb #(
    parameter int DW    = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           ack,
    output logic [DW-1:0]             fifo_din,
    output logic                      fifo_we,
    input  logic                      fifo_full,
    input  logic                      fifo_full_n,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int CW = $clog2(BURST + 1);
    localparam int IW = $clog2(NREQ);

    // After reset the pointer sits on the highest index so producer 0 wins first.
    localparam logic [IW-1:0] c_rr_init   = IW'(NREQ - 1);
    localparam logic [CW-1:0] c_burst_max = CW'(BURST);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_owner_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_rr_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;

    logic [IW-1:0]   w_cand [NREQ];
    logic [IW-1:0]   w_pick;
    logic            w_any_req;
    logic            w_owner_req;
    logic            w_owner_last;
    logic [DW-1:0]   w_owner_data;
    logic            w_live;

    // Candidate k is the producer k+1 places after the last owner, modulo NREQ.
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        logic [IW:0] w_sum;
        assign w_sum     = {1'b0, r_rr_ptr} + (IW+1)'(k + 1);
        assign w_cand[k] = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ))
                                                    : IW'(w_sum);
    end

    // Nearest requesting candidate wins; scanning far-to-near lets the nearest overwrite.
    always_comb begin
        w_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                w_pick = w_cand[k];
            end
        end
    end

    assign w_any_req = |req;

    // Select the current owner's request, last flag and data.
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_last = 1'b0;
        w_owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_owner_req  = req[i];
                w_owner_last = req_last[i];
                w_owner_data = req_data[i*DW +: DW];
            end
        end
    end

    // A reset or clear cycle must never produce a write, even mid-burst.
    assign w_live    = rst & ~clr;
    assign busy      = (r_state == ST_XFER);
    assign fifo_we   = w_live & busy & w_owner_req & ~fifo_full;
    assign fifo_din  = fifo_we ? w_owner_data : '0;
    assign grant_id  = r_owner;
    assign w_cnt_inc = r_cnt + CW'(1);

    for (genvar i = 0; i < NREQ; i++) begin : g_ack
        assign ack[i] = fifo_we & (r_owner == IW'(i));
    end

    // Next-state logic: grant in IDLE, count accepted words in XFER.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req && !fifo_full_n) begin
                    w_state_nxt = ST_XFER;
                    w_owner_nxt = w_pick;
                    w_rr_nxt    = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_XFER: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (!fifo_full) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_owner_last || (w_cnt_inc == c_burst_max)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= c_rr_init;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    a_no_we_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_we && fifo_full));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(ack));
    a_ack_needs_busy: assert property (@(posedge clk) disable iff (!rst)
        (ack != '0) |-> busy);

endmodule
`default_nettype wire

// File: tb/tb_sc_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_fifo_wr_arb
// Description : Directed bench for sc_fifo_wr_arb with per-producer word
//               queues and an expected-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_fifo_wr_arb;

    localparam int DW    = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } sb_t;

    logic              clk;
    logic              rst;
    logic              clr;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     fifo_din;
    logic              fifo_we;
    logic              fifo_full;
    logic              fifo_full_n;
    logic [1:0]        grant_id;
    logic              busy;

    sc_fifo_wr_arb #(
        .DW    (DW),
        .NREQ  (NREQ),
        .BURST (BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .fifo_din    (fifo_din),
        .fifo_we     (fifo_we),
        .fifo_full   (fifo_full),
        .fifo_full_n (fifo_full_n),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    word_t       pq [NREQ][$];
    sb_t         sb [$];
    logic [31:0] we_hist;
    logic [7:0]  seq;
    int          n_pass;
    int          n_fail;

    // Control values applied at the next negedge.
    logic        t_rst;
    logic        t_clr;
    logic        t_full;
    logic        t_full_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int id, input int n, input bit last_end);
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.data = seq;
            w.last = last_end && (k == n - 1);
            seq    = seq + 8'd1;
            pq[id].push_back(w);
        end
    endtask

    task automatic expect_word(input int id, input int idx);
        sb_t e;
        e.id   = 2'(id);
        e.data = pq[id][idx].data;
        sb.push_back(e);
    endtask

    // One cycle: drive at negedge, sample 1ns later, retire accepted words.
    task automatic tick();
        @(negedge clk);
        rst         = t_rst;
        clr         = t_clr;
        fifo_full   = t_full;
        fifo_full_n = t_full_n;
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() > 0) begin
                req[i]               = 1'b1;
                req_data[i*DW +: DW] = pq[i][0].data;
                req_last[i]          = pq[i][0].last;
            end else begin
                req[i]               = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
        #1;
        we_hist = {we_hist[30:0], fifo_we};
        if (fifo_we) begin
            assert (sb.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL unexpected_write: observed din %0h expected no write", fifo_din);
            end
            if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                check("din", 32'(fifo_din), 32'(e.data));
                check("grant_id", 32'(grant_id), 32'(e.id));
                check("ack", 32'(ack), 32'(1) << e.id);
            end
        end else begin
            check("ack_idle", 32'(ack), 32'd0);
            check("din_idle", 32'(fifo_din), 32'd0);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && pq[i].size() > 0) begin
                void'(pq[i].pop_front());
            end
        end
    endtask

    initial begin
        n_pass   = 0;
        n_fail   = 0;
        seq      = 8'h10;
        we_hist  = '0;
        t_rst    = 1'b0;
        t_clr    = 1'b0;
        t_full   = 1'b0;
        t_full_n = 1'b0;

        // Reset held low for two cycles.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(fifo_we), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);

        // Single producer, six words without last: 4 + gap + 2.
        t_rst = 1'b1;
        load(0, 6, 1'b0);
        for (int k = 0; k < 6; k++) expect_word(0, k);
        we_hist = '0;
        repeat (9) tick();
        check("single_pattern", we_hist & 32'h1FF, 32'b011110110);
        check("single_sb_empty", 32'(sb.size()), 32'd0);

        // Clear, then round robin with all four requesting.
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        load(0, 8, 1'b0);
        load(1, 4, 1'b0);
        load(2, 4, 1'b0);
        load(3, 4, 1'b0);
        for (int k = 0; k < 4; k++) expect_word(0, k);
        for (int k = 0; k < 4; k++) expect_word(1, k);
        for (int k = 0; k < 4; k++) expect_word(2, k);
        for (int k = 0; k < 4; k++) expect_word(3, k);
        for (int k = 4; k < 8; k++) expect_word(0, k);
        we_hist = '0;
        repeat (25) tick();
        check("rr_pattern", we_hist & 32'h1FF_FFFF, 32'b0111101111011110111101111);
        check("rr_sb_empty", 32'(sb.size()), 32'd0);

        // Producer 2 ends its packet after two words; producer 3 is next.
        load(2, 2, 1'b1);
        load(3, 1, 1'b0);
        expect_word(2, 0);
        expect_word(2, 1);
        expect_word(3, 0);
        we_hist = '0;
        repeat (6) tick();
        check("last_pattern", we_hist & 32'h3F, 32'b011010);
        check("last_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        check("last_idle_busy", 32'(busy), 32'd0);

        // Full stall for three cycles after two words.
        load(1, 4, 1'b0);
        for (int k = 0; k < 4; k++) expect_word(1, k);
        we_hist = '0;
        repeat (3) tick();
        t_full = 1'b1;
        repeat (3) tick();
        check("stall_busy", 32'(busy), 32'd1);
        t_full = 1'b0;
        repeat (2) tick();
        check("stall_pattern", we_hist & 32'hFF, 32'b01100011);
        tick();
        check("stall_done_busy", 32'(busy), 32'd0);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Almost-full throttles new grants.
        t_full_n = 1'b1;
        load(1, 1, 1'b1);
        expect_word(1, 0);
        tick();
        check("thr_busy0", 32'(busy), 32'd0);
        tick();
        tick();
        check("thr_busy2", 32'(busy), 32'd0);
        t_full_n = 1'b0;
        tick();
        tick();
        check("thr_gid", 32'(grant_id), 32'd1);
        check("thr_busy", 32'(busy), 32'd1);
        check("thr_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        check("thr_done_busy", 32'(busy), 32'd0);

        // Clear mid-burst after two words, then arbitration restarts at 0.
        load(0, 4, 1'b0);
        load(1, 4, 1'b0);
        load(2, 4, 1'b0);
        load(3, 4, 1'b0);
        expect_word(2, 0);
        expect_word(2, 1);
        expect_word(0, 0);
        we_hist = '0;
        repeat (3) tick();
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        tick();
        check("clr_idle_busy", 32'(busy), 32'd0);
        tick();
        check("clr_pattern", we_hist & 32'h3F, 32'b011001);
        check("clr_gid", 32'(grant_id), 32'd0);
        check("clr_sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < NREQ; i++) pq[i].delete();
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
`default_nettype wire
